// File: rtl/move_if.sv
// Board, score and status bus between the 2048 move sequencer and its
// environment (buttons, LFSR, renderer, seven-segment display).
interface move_if #(
  parameter int W = 12
);
  logic [3:0]   buttons;
  logic [3:0]   rand_pos;
  logic [W-1:0] matrix [3:0][3:0];
  logic [15:0]  score;
  logic         busy;
  logic         won;
  logic         lost;
  logic [2:0]   state;

  modport master (
    output buttons, rand_pos,
    input  matrix, score, busy, won, lost, state
  );

  modport slave (
    input  buttons, rand_pos,
    output matrix, score, busy, won, lost, state
  );
endinterface

// File: rtl/move_controller.sv
// 2048 move sequencer: one line slid/merged per cycle, then spawn and
// won/lost evaluation; the board register feeds the renderer directly.
module move_controller #(
  parameter int W         = 12,
  parameter int SPAWN_VAL = 2,
  parameter int WIN_VAL   = 2048
) (
  input logic   clk,
  input logic   rst_game,
  move_if.slave bus
);

  localparam logic [W-1:0] LP_SPAWN = W'(SPAWN_VAL);
  localparam logic [W-1:0] LP_WIN   = W'(WIN_VAL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_SPAWN = 3'd4,
    S_EVAL  = 3'd5,
    S_WAIT  = 3'd6,
    S_OVER  = 3'd7
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_board [3:0][3:0];
  logic [15:0]  r_score;
  logic         r_won;
  logic         r_lost;
  logic [1:0]   r_dir;
  logic [1:0]   r_line;
  logic         r_changed;
  logic [3:0]   r_idx;

  logic         w_one;
  logic [1:0]   w_dir;
  logic [W-1:0] w_in  [4];
  logic [W-1:0] w_c   [4];
  logic [W-1:0] w_m   [4];
  logic [W-1:0] w_out [4];
  logic [16:0]  w_msum;
  logic         w_diff;
  logic [16:0]  w_sum;
  logic [15:0]  w_score_nx;
  logic         w_won;
  logic         w_lost;

  // dir code equals the index of the pressed button bit
  assign w_one = $onehot(~bus.buttons);

  always_comb begin
    w_dir = 2'd0;
    if (w_one) begin
      unique case (1'b1)
        !bus.buttons[3]: w_dir = 2'd3;
        !bus.buttons[2]: w_dir = 2'd2;
        !bus.buttons[1]: w_dir = 2'd1;
        !bus.buttons[0]: w_dir = 2'd0;
      endcase
    end
  end

  always_comb begin
    int n;
    for (int k = 0; k < 4; k++) begin
      case (r_dir)
        2'd3:    w_in[k] = r_board[r_line][k[1:0]];
        2'd0:    w_in[k] = r_board[r_line][2'(3 - k)];
        2'd1:    w_in[k] = r_board[k[1:0]][r_line];
        default: w_in[k] = r_board[2'(3 - k)][r_line];
      endcase
    end
    for (int k = 0; k < 4; k++) w_c[k] = '0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (w_in[k] != '0) begin
        w_c[n[1:0]] = w_in[k];
        n = n + 1;
      end
    end
    w_m    = w_c;
    w_msum = '0;
    // a merged slot is zeroed, so it cannot merge again
    for (int i = 0; i < 3; i++) begin
      if (w_m[i] != '0 && w_m[i] == w_m[i+1]) begin
        w_m[i]   = w_m[i] + w_m[i];
        w_m[i+1] = '0;
        w_msum   = w_msum + 17'(w_m[i]);
      end
    end
    for (int k = 0; k < 4; k++) w_out[k] = '0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (w_m[k] != '0) begin
        w_out[n[1:0]] = w_m[k];
        n = n + 1;
      end
    end
    w_diff = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (w_out[k] != w_in[k]) w_diff = 1'b1;
    end
  end

  assign w_sum      = {1'b0, r_score} + w_msum;
  assign w_score_nx = w_sum[16] ? 16'hFFFF : w_sum[15:0];

  always_comb begin
    w_won  = 1'b0;
    w_lost = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r_board[r[1:0]][c[1:0]] == LP_WIN) w_won = 1'b1;
        if (r_board[r[1:0]][c[1:0]] == '0) w_lost = 1'b0;
        if (c < 3 && r_board[r[1:0]][c[1:0]] == r_board[r[1:0]][2'(c + 1)])
          w_lost = 1'b0;
        if (r < 3 && r_board[r[1:0]][c[1:0]] == r_board[2'(r + 1)][c[1:0]])
          w_lost = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_game) begin
    if (!rst_game) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          r_board[r[1:0]][c[1:0]] <= '0;
      r_board[0][0] <= LP_SPAWN;
      r_board[3][3] <= LP_SPAWN;
      r_state   <= S_IDLE;
      r_score   <= '0;
      r_won     <= 1'b0;
      r_lost    <= 1'b0;
      r_dir     <= 2'd0;
      r_line    <= 2'd0;
      r_changed <= 1'b0;
      r_idx     <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_one) begin
            r_dir   <= w_dir;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_changed <= 1'b0;
          r_line    <= 2'd0;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          for (int k = 0; k < 4; k++) begin
            case (r_dir)
              2'd3:    r_board[r_line][k[1:0]]   <= w_out[k];
              2'd0:    r_board[r_line][2'(3 - k)] <= w_out[k];
              2'd1:    r_board[k[1:0]][r_line]   <= w_out[k];
              default: r_board[2'(3 - k)][r_line] <= w_out[k];
            endcase
          end
          r_changed <= r_changed | w_diff;
          r_score   <= w_score_nx;
          r_line    <= r_line + 2'd1;
          if (r_line == 2'd3) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (r_changed) begin
            r_idx   <= bus.rand_pos;
            r_state <= S_SPAWN;
          end else begin
            r_state <= S_EVAL;
          end
        end
        S_SPAWN: begin
          if (r_board[r_idx[3:2]][r_idx[1:0]] == '0) begin
            r_board[r_idx[3:2]][r_idx[1:0]] <= LP_SPAWN;
            r_state <= S_EVAL;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_EVAL: begin
          r_won   <= w_won;
          r_lost  <= w_lost;
          r_state <= (w_won | w_lost) ? S_OVER : S_WAIT;
        end
        S_WAIT: begin
          if (bus.buttons == 4'hF) r_state <= S_IDLE;
        end
        S_OVER: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.matrix = r_board;
  assign bus.score  = r_score;
  assign bus.won    = r_won;
  assign bus.lost   = r_lost;
  assign bus.state  = r_state;
  assign bus.busy   = (r_state == S_LOAD)  || (r_state == S_SHIFT) ||
                      (r_state == S_CHECK) || (r_state == S_SPAWN) ||
                      (r_state == S_EVAL);

endmodule

// File: tb/tb_move_controller.sv
// Random-play bench for move_controller against a queue-based 2048 model
// (lowered WIN_VAL so games end by both winning and losing).
module tb_move_controller;

  localparam int W  = 12;
  localparam int WV = 128;

  logic clk = 1'b0;
  logic rst_game = 1'b0;

  move_if #(.W(W)) bus ();

  move_controller #(
    .W(W), .SPAWN_VAL(2), .WIN_VAL(WV)
  ) dut (
    .clk(clk), .rst_game(rst_game), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int mb [4][4];
  int msc;
  bit mwon, mlost, mover;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void cell_of(input int d, l, k, output int r, c);
    case (d)
      3: begin r = l;     c = k;     end
      0: begin r = l;     c = 3 - k; end
      1: begin r = k;     c = l;     end
      default: begin r = 3 - k; c = l; end
    endcase
  endfunction

  function automatic void model_reset();
    foreach (mb[r, c]) mb[r][c] = 0;
    mb[0][0] = 2;
    mb[3][3] = 2;
    msc = 0; mwon = 0; mlost = 0; mover = 0;
  endfunction

  task automatic model_move(input int d, input int rp, output int spn);
    int q[$];
    int o[$];
    int v[4];
    int r, c, i, idx;
    bit ch;
    ch = 0; spn = 0;
    for (int l = 0; l < 4; l++) begin
      q.delete(); o.delete();
      for (int k = 0; k < 4; k++) begin
        cell_of(d, l, k, r, c);
        v[k] = mb[r][c];
        if (v[k] != 0) q.push_back(v[k]);
      end
      i = 0;
      while (i < q.size()) begin
        if (i + 1 < q.size() && q[i] == q[i+1]) begin
          o.push_back((2 * q[i]) % (1 << W));
          msc = msc + (2 * q[i]) % (1 << W);
          if (msc > 65535) msc = 65535;
          i += 2;
        end else begin
          o.push_back(q[i]);
          i += 1;
        end
      end
      while (o.size() < 4) o.push_back(0);
      for (int k = 0; k < 4; k++) begin
        cell_of(d, l, k, r, c);
        if (o[k] != v[k]) ch = 1;
        mb[r][c] = o[k];
      end
    end
    if (ch) begin
      for (int j = 0; j < 16; j++) begin
        idx = (rp + j) % 16;
        if (mb[idx/4][idx%4] == 0) begin
          mb[idx/4][idx%4] = 2;
          spn = j + 1;
          break;
        end
      end
    end
    mwon = 0; mlost = 1;
    foreach (mb[a, b]) begin
      if (mb[a][b] == WV) mwon = 1;
      if (mb[a][b] == 0) mlost = 0;
      if (b < 3 && mb[a][b] == mb[a][b+1]) mlost = 0;
      if (a < 3 && mb[a][b] == mb[a+1][b]) mlost = 0;
    end
    mover = mwon | mlost;
  endtask

  task automatic chk_board(input string tag);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("%s_m%0d%0d", tag, r, c), int'(bus.matrix[r][c]), mb[r][c]);
  endtask

  task automatic chk_reset_state(input string tag);
    chk_board(tag);
    chk({tag, "_score"}, int'(bus.score), 0);
    chk({tag, "_won"}, int'(bus.won), 0);
    chk({tag, "_lost"}, int'(bus.lost), 0);
    chk({tag, "_state"}, int'(bus.state), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_game = 1'b0;
    bus.buttons = 4'hF;
    model_reset();
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_game = 1'b1;
  endtask

  task automatic do_move(input int d, input int rp, input int hold);
    int spn, cnt;
    @(negedge clk);
    bus.buttons  = 4'hF ^ (4'h1 << d);
    bus.rand_pos = rp[3:0];
    model_move(d, rp, spn);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) chk("load_state", int'(bus.state), 1);
    end while (bus.state != 3'd6 && bus.state != 3'd7 && cnt < 60);
    chk("latency", cnt, 8 + spn);
    chk_board("move");
    chk("score", int'(bus.score), msc);
    chk("won", int'(bus.won), int'(mwon));
    chk("lost", int'(bus.lost), int'(mlost));
    chk("end_state", int'(bus.state), mover ? 7 : 6);
    chk("end_busy", int'(bus.busy), 0);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("hold_state", int'(bus.state), mover ? 7 : 6);
      chk_board("hold");
    end
    bus.buttons = 4'hF;
    @(negedge clk);
    chk("release_state", int'(bus.state), mover ? 7 : 0);
  endtask

  task automatic press_in_over(input int d);
    @(negedge clk);
    bus.buttons = 4'hF ^ (4'h1 << d);
    repeat (12) @(negedge clk);
    chk("over_state", int'(bus.state), 7);
    chk("over_score", int'(bus.score), msc);
    chk_board("over");
    bus.buttons = 4'hF;
    repeat (2) @(negedge clk);
    chk("over_rel", int'(bus.state), 7);
  endtask

  int games_won, games_lost;

  initial begin
    bus.buttons  = 4'hF;
    bus.rand_pos = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // first move from the initial board: left
    do_move(3, int'($urandom_range(0, 15)), 0);

    // two buttons low: no move
    @(negedge clk);
    bus.buttons = 4'b0011;
    repeat (5) @(negedge clk);
    chk("two_btn_state", int'(bus.state), 0);
    chk_board("two_btn");
    bus.buttons = 4'hF;

    // held press gives exactly one move
    do_move(1, int'($urandom_range(0, 15)), 6);

    // reset in the middle of SHIFT
    @(negedge clk);
    bus.buttons = 4'b1110;
    repeat (3) @(negedge clk);
    chk("mid_shift_state", int'(bus.state), 2);
    rst_game = 1'b0;
    model_reset();
    #1;
    chk_reset_state("mid_rst");
    @(negedge clk);
    bus.buttons = 4'hF;
    rst_game = 1'b1;

    games_won = 0; games_lost = 0;
    for (int g = 0; g < 5; g++) begin
      do_reset();
      for (int m = 0; m < 250 && !mover; m++)
        do_move(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 0);
      if (mover) begin
        if (mwon) games_won++;
        if (mlost) games_lost++;
        press_in_over(int'($urandom_range(0, 3)));
      end
    end
    $display("games won=%0d lost=%0d", games_won, games_lost);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
